// File: rtl/btn_conditioner_pkg.sv
// Shared constants and helpers for the stopwatch input conditioner.
package btn_cond_pkg;

  // Channel index of each raw input inside the packed channel vectors
  localparam int CH_SEL = 0;
  localparam int CH_ADJ = 1;
  localparam int CH_RST = 2;
  localparam int CH_PSE = 3;
  localparam int NUM_CH = 4;

  // Debounce counter width; it must be able to hold DB_CYCLES itself
  function automatic int cnt_width(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage : btn_cond_pkg

// File: rtl/btn_conditioner_if.sv
// Board-side bundle: raw switch/button inputs and the conditioned control outputs.
interface btn_conditioner_if;

  logic sw_sel;
  logic sw_adj;
  logic btn_rst;
  logic btn_pse;
  logic sel;
  logic adj;
  logic clr;
  logic pse;

  // Board / stimulus side: drives the raw inputs, observes the clean controls
  modport master (
    output sw_sel,
    output sw_adj,
    output btn_rst,
    output btn_pse,
    input  sel,
    input  adj,
    input  clr,
    input  pse
  );

  // Conditioner side
  modport slave (
    input  sw_sel,
    input  sw_adj,
    input  btn_rst,
    input  btn_pse,
    output sel,
    output adj,
    output clr,
    output pse
  );

endinterface : btn_conditioner_if

// File: rtl/btn_conditioner_debounce_chan.sv
// One input channel: multi-flop synchroniser followed by a stable-count debouncer.
// q only moves after the synchronised input has differed from it for DB_CYCLES
// consecutive cycles; any return to q restarts the count from zero.
module debounce_chan
  import btn_cond_pkg::*;
#(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q
);

  localparam int             CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  logic                   q_r;
  logic                   q_nxt_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_nxt_s;

  assign s_s = sync_r[SYNC_STAGES-1];
  assign q   = q_r;

  // Synchroniser chain: shift the asynchronous input through SYNC_STAGES flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Debounce decision: count consecutive differing cycles, accept on the last one
  always_comb begin
    q_nxt_s   = q_r;
    cnt_nxt_s = {CW{1'b0}};
    if (s_s == q_r) begin
      q_nxt_s   = q_r;
      cnt_nxt_s = {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      q_nxt_s   = s_s;
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      q_nxt_s   = q_r;
      cnt_nxt_s = cnt_r + CW'(1'b1);
    end
  end

  // Stable state and counter registers; reset discards any partial count
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= 1'b0;
      cnt_r <= {CW{1'b0}};
    end else begin
      q_r   <= q_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule : debounce_chan

// File: rtl/btn_conditioner.sv
// Stopwatch front end: debounces two switches and two buttons, turns the reset
// button into a one-cycle clear pulse and the pause button into a run/pause level.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  btn_conditioner_if.slave  bus
);

  logic [NUM_CH-1:0] raw_s;
  logic [NUM_CH-1:0] q_s;

  logic rst_q_d_r;
  logic pse_q_d_r;
  logic press_rst_s;
  logic press_pse_s;
  logic pse_nxt_s;

  logic sel_r;
  logic adj_r;
  logic clr_r;
  logic pse_r;

  assign raw_s[CH_SEL] = bus.sw_sel;
  assign raw_s[CH_ADJ] = bus.sw_adj;
  assign raw_s[CH_RST] = bus.btn_rst;
  assign raw_s[CH_PSE] = bus.btn_pse;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    debounce_chan #(
      .DB_CYCLES   (DB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk (clk),
      .rst (rst),
      .din (raw_s[g]),
      .q   (q_s[g])
    );
  end

  // Rising edges of the debounced buttons; release edges are ignored
  always_comb begin
    press_rst_s = q_s[CH_RST] & ~rst_q_d_r;
    press_pse_s = q_s[CH_PSE] & ~pse_q_d_r;
  end

  // Pause toggle: a clear always returns to running, even if pause was pressed too
  always_comb begin
    pse_nxt_s = pse_r;
    if (press_rst_s) begin
      pse_nxt_s = 1'b0;
    end else if (press_pse_s) begin
      pse_nxt_s = ~pse_r;
    end else begin
      pse_nxt_s = pse_r;
    end
  end

  // Edge-detect delay registers and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q_d_r <= 1'b0;
      pse_q_d_r <= 1'b0;
      sel_r     <= 1'b0;
      adj_r     <= 1'b0;
      clr_r     <= 1'b0;
      pse_r     <= 1'b0;
    end else begin
      rst_q_d_r <= q_s[CH_RST];
      pse_q_d_r <= q_s[CH_PSE];
      sel_r     <= q_s[CH_SEL];
      adj_r     <= q_s[CH_ADJ];
      clr_r     <= press_rst_s;
      pse_r     <= pse_nxt_s;
    end
  end

  assign bus.sel = sel_r;
  assign bus.adj = adj_r;
  assign bus.clr = clr_r;
  assign bus.pse = pse_r;

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DB_CYCLES=4, SYNC_STAGES=2.
// The reference model works on the sampled raw history: a channel's accepted
// level flips once its input, seen SYNC_STAGES edges late, has disagreed with
// the accepted level on DB_CYCLES consecutive edges.
module tb_btn_conditioner;
  import btn_cond_pkg::*;

  localparam int DB   = 4;
  localparam int SY   = 2;
  localparam int MAXE = 8192;

  typedef struct packed {
    logic sel;
    logic adj;
    logic clr;
    logic pse;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_conditioner_if bus ();

  btn_conditioner #(
    .DB_CYCLES   (DB),
    .SYNC_STAGES (SY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] hist [0:MAXE-1];
  logic [3:0] qm   [0:MAXE-1];
  logic       pse_m = 1'b0;
  int         k = 0;
  exp_t       sbq [$];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [3:0] hget(input int i);
    if (i < 0) return 4'b0000;
    return hist[i];
  endfunction

  function automatic logic [3:0] qget(input int i);
    if (i < 0) return 4'b0000;
    return qm[i];
  endfunction

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of raw inputs, then push the model's post-edge outputs
  task automatic step(input logic [3:0] r, input logic rs);
    exp_t       e;
    logic [3:0] prev;
    logic [3:0] prev2;
    logic [3:0] h;
    logic [3:0] qn;
    logic       want;
    bit         all_diff;
    @(negedge clk);
    bus.sw_sel  = r[CH_SEL];
    bus.sw_adj  = r[CH_ADJ];
    bus.btn_rst = r[CH_RST];
    bus.btn_pse = r[CH_PSE];
    rst         = rs;
    @(posedge clk);
    hist[k] = r;
    e = '0;
    if (rs) begin
      for (int j = 0; j < SY; j++) if (k - j >= 0) hist[k-j] = 4'b0000;
      qm[k] = 4'b0000;
      pse_m = 1'b0;
    end else begin
      prev  = qget(k - 1);
      prev2 = qget(k - 2);
      qn    = prev;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        want     = ~prev[ch];
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) begin
          h = hget(k - SY - j);
          if (h[ch] != want) all_diff = 1'b0;
        end
        if (all_diff) qn[ch] = want;
      end
      qm[k] = qn;
      e.sel = prev[CH_SEL];
      e.adj = prev[CH_ADJ];
      e.clr = prev[CH_RST] & ~prev2[CH_RST];
      if (e.clr) pse_m = 1'b0;
      else if (prev[CH_PSE] & ~prev2[CH_PSE]) pse_m = ~pse_m;
      e.pse = pse_m;
    end
    sbq.push_back(e);
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0);
  endtask

  // Monitor: outputs are sampled every falling edge and compared with the queue head
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sel", bus.sel, e.sel);
      chk("adj", bus.adj, e.adj);
      chk("clr", bus.clr, e.clr);
      chk("pse", bus.pse, e.pse);
    end
  end

  initial begin
    int         lat;
    int         clr_cnt;
    logic [3:0] lvl;
    int         hold [NUM_CH];

    bus.sw_sel  = 1'b1;
    bus.sw_adj  = 1'b1;
    bus.btn_rst = 1'b1;
    bus.btn_pse = 1'b1;

    // 1: reset with every raw input high
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    idle(8);

    // 2: select switch edge, latency SYNC_STAGES + DB_CYCLES + 1
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      step(4'b0001, 1'b0);
      #1;
      if (lat < 0 && bus.sel === 1'b1) lat = i;
    end
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL sel_latency: got %0d cycles, expected 7", lat);
    end
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);

    // 3: bouncing pause press, release, press again
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) step(4'b1000, 1'b0);
    idle(10);
    for (int i = 0; i < 10; i++) step(4'b1000, 1'b0);
    idle(10);

    // 4: long reset-button hold gives one pulse; short pulse gives none
    clr_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(4'b0100, 1'b0);
      #1;
      if (bus.clr === 1'b1) clr_cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 1'b0);
      #1;
      if (bus.clr === 1'b1) clr_cnt++;
    end
    checks++;
    if (clr_cnt != 1) begin
      errors++;
      $display("FAIL clr_hold_count: got %0d pulses, expected 1", clr_cnt);
    end
    clr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b0);
      #1;
      if (bus.clr === 1'b1) clr_cnt++;
    end
    for (int i = 0; i < 15; i++) begin
      step(4'b0000, 1'b0);
      #1;
      if (bus.clr === 1'b1) clr_cnt++;
    end
    checks++;
    if (clr_cnt != 0) begin
      errors++;
      $display("FAIL clr_glitch_count: got %0d pulses, expected 0", clr_cnt);
    end

    // 5: pause, then reset and pause buttons together
    for (int i = 0; i < 10; i++) step(4'b1000, 1'b0);
    idle(10);
    for (int i = 0; i < 10; i++) step(4'b1100, 1'b0);
    idle(10);

    // 6: block reset two cycles into a pause debounce
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0);
    idle(10);
    for (int i = 0; i < 20; i++) step(4'b1000, 1'b0);
    idle(10);

    // Random bouncing on all channels with occasional block reset
    lvl = 4'b0000;
    for (int ch = 0; ch < NUM_CH; ch++) hold[ch] = 1;
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        hold[ch]--;
        if (hold[ch] <= 0) begin
          lvl[ch]  = ~lvl[ch];
          hold[ch] = int'($urandom_range(1, 9));
        end
      end
      step(lvl, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
    end
    idle(12);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_btn_conditioner
